// File: rtl/rr_onehot_arb_pkg.sv
// Shared types and constants for the rotating-priority one-hot arbiter.
// Holds the FSM state encoding and the grant-tenure counter width.
package rr_onehot_arb_pkg;

    localparam int HOLD_W = 8;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

endpackage

// File: rtl/rr_onehot_arb_pick.sv
// Combinational rotating-priority picker: first set request at or
// above ptr, wrapping from the top requester back to requester 0.
module rr_pick
    import rr_onehot_arb_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic [NUM_REQ-1:0]         pick,
    output logic [$clog2(NUM_REQ)-1:0] pick_idx,
    output logic                       any
);

    localparam int IW = $clog2(NUM_REQ);

    logic hit;
    int   j;

    always_comb begin
        pick     = '0;
        pick_idx = '0;
        hit      = 1'b0;
        j        = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            j = (int'(ptr) + i) % NUM_REQ;
            if (!hit && req[j]) begin
                hit      = 1'b1;
                pick[j]  = 1'b1;
                pick_idx = IW'(j);
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/rr_onehot_arb.sv
// Round-robin arbiter with registered one-hot grant, bounded tenure
// and a one-bubble gap between consecutive grants.
module rr_onehot_arb
    import rr_onehot_arb_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int MAX_HOLD = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_i,
    input  logic                       done_i,
    output logic [NUM_REQ-1:0]         gnt_o,
    output logic [$clog2(NUM_REQ)-1:0] gnt_idx_o,
    output logic                       gnt_valid_o,
    output logic                       timeout_o
);

    localparam int IW = $clog2(NUM_REQ);

    state_t              state;
    logic [IW-1:0]       ptr;
    logic [HOLD_W-1:0]   hold_cnt;

    logic [NUM_REQ-1:0]  pick;
    logic [IW-1:0]       pick_idx;
    logic                pick_any;

    logic                hold_hit;
    logic                req_drop;
    logic                rel;
    logic [IW-1:0]       next_ptr;

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req      (req_i),
        .ptr      (ptr),
        .pick     (pick),
        .pick_idx (pick_idx),
        .any      (pick_any)
    );

    assign hold_hit = (hold_cnt == HOLD_W'(MAX_HOLD - 1));
    assign req_drop = ~req_i[gnt_idx_o];
    assign rel      = done_i | req_drop | hold_hit;
    assign next_ptr = (gnt_idx_o == IW'(NUM_REQ - 1))
                    ? '0 : gnt_idx_o + IW'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            ptr         <= '0;
            hold_cnt    <= '0;
            gnt_o       <= '0;
            gnt_idx_o   <= '0;
            gnt_valid_o <= 1'b0;
            timeout_o   <= 1'b0;
        end else begin
            timeout_o <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (pick_any) begin
                        state       <= GRANT;
                        gnt_o       <= pick;
                        gnt_idx_o   <= pick_idx;
                        gnt_valid_o <= 1'b1;
                        hold_cnt    <= '0;
                    end
                end
                GRANT: begin
                    if (rel) begin
                        state       <= IDLE;
                        ptr         <= next_ptr;
                        gnt_o       <= '0;
                        gnt_idx_o   <= '0;
                        gnt_valid_o <= 1'b0;
                        // Only a pure tenure expiry is a timeout.
                        timeout_o   <= hold_hit & ~done_i & ~req_drop;
                    end else if (hold_cnt != '1) begin
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rr_onehot_arb.sv
// Self-checking bench for rr_onehot_arb: directed scenarios feed a
// grant scoreboard; a negedge monitor pops and compares each new grant.
module tb_rr_onehot_arb;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] req_i;
    logic       done_i;
    logic [3:0] gnt_o;
    logic [1:0] gnt_idx_o;
    logic       gnt_valid_o;
    logic       timeout_o;

    typedef struct {
        logic [3:0] gnt;
        logic [1:0] idx;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    logic prev_v = 1'b0;

    rr_onehot_arb #(
        .NUM_REQ  (4),
        .MAX_HOLD (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_i       (req_i),
        .done_i      (done_i),
        .gnt_o       (gnt_o),
        .gnt_idx_o   (gnt_idx_o),
        .gnt_valid_o (gnt_valid_o),
        .timeout_o   (timeout_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic push(input logic [3:0] g, input logic [1:0] i);
        exp_t e;
        e.gnt = g;
        e.idx = i;
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        req_i  = '0;
        done_i = 1'b0;
        cyc();
        cyc();
        chk("rst_gnt", 32'(gnt_o), 0);
        chk("rst_idx", 32'(gnt_idx_o), 0);
        chk("rst_vld", 32'(gnt_valid_o), 0);
        chk("rst_to", 32'(timeout_o), 0);
        reset = 1'b0;
    endtask

    // Invariants every cycle, plus scoreboard pop on each new grant.
    always @(negedge clk) begin
        exp_t e;
        chk("vld_map", 32'(gnt_valid_o), 32'(|gnt_o));
        chk("onehot", 32'($countones(gnt_o) <= 1), 1);
        chk("idx_map", 32'(gnt_o),
            gnt_valid_o ? 32'(4'b0001 << gnt_idx_o) : 32'd0);
        if (gnt_valid_o && !prev_v) begin
            if (exp_q.size() == 0) begin
                chk("sb_unexp", 32'(gnt_o), 0);
            end else begin
                e = exp_q.pop_front();
                chk("sb_gnt", 32'(gnt_o), 32'(e.gnt));
                chk("sb_idx", 32'(gnt_idx_o), 32'(e.idx));
            end
        end
        prev_v = gnt_valid_o;
    end

    initial begin
        reset  = 1'b1;
        req_i  = '0;
        done_i = 1'b0;
        do_reset();

        // Idle with no requests stays idle.
        cyc();
        cyc();
        chk("idle_gnt", 32'(gnt_o), 0);

        // Single request, one-cycle latency.
        req_i = 4'b0100;
        push(4'b0100, 2);
        chk("lat_pre", 32'(gnt_valid_o), 0);
        cyc();
        chk("lat_gnt", 32'(gnt_o), 32'h4);
        chk("lat_idx", 32'(gnt_idx_o), 2);
        chk("lat_vld", 32'(gnt_valid_o), 1);
        done_i = 1'b1;
        req_i  = '0;
        cyc();
        done_i = 1'b0;
        chk("done_rel", 32'(gnt_valid_o), 0);
        chk("done_to", 32'(timeout_o), 0);

        // Fairness rotation with one-cycle done pulses.
        do_reset();
        req_i = 4'b1111;
        push(4'b0001, 0);
        push(4'b0010, 1);
        push(4'b0100, 2);
        push(4'b1000, 3);
        push(4'b0001, 0);
        for (int k = 0; k < 5; k++) begin
            cyc();
            chk("rot_on", 32'(gnt_valid_o), 1);
            done_i = 1'b1;
            if (k == 4) req_i = '0;
            cyc();
            done_i = 1'b0;
            chk("rot_bubble", 32'(gnt_valid_o), 0);
        end

        // Tenure expiry: 8 grant cycles, timeout pulse, regrant.
        req_i = 4'b0001;
        push(4'b0001, 0);
        push(4'b0001, 0);
        for (int k = 0; k < 8; k++) begin
            cyc();
            chk("hold_on", 32'(gnt_o), 1);
        end
        cyc();
        chk("to_gnt", 32'(gnt_o), 0);
        chk("to_pulse", 32'(timeout_o), 1);
        cyc();
        chk("to_regrant", 32'(gnt_o), 1);
        chk("to_clear", 32'(timeout_o), 0);
        done_i = 1'b1;
        req_i  = '0;
        cyc();
        done_i = 1'b0;
        chk("to_done_rel", 32'(timeout_o), 0);

        // done coinciding with expiry suppresses timeout.
        req_i = 4'b0001;
        push(4'b0001, 0);
        for (int k = 0; k < 8; k++) cyc();
        chk("co_last", 32'(gnt_o), 1);
        done_i = 1'b1;
        cyc();
        done_i = 1'b0;
        req_i  = '0;
        chk("co_gnt", 32'(gnt_o), 0);
        chk("co_to", 32'(timeout_o), 0);

        // Request drop releases; pointer moves past dropped grantee.
        req_i = 4'b1011;
        push(4'b0010, 1);
        cyc();
        chk("drop_on", 32'(gnt_o), 32'h2);
        req_i = 4'b1001;
        push(4'b1000, 3);
        cyc();
        chk("drop_rel", 32'(gnt_o), 0);
        chk("drop_to", 32'(timeout_o), 0);
        cyc();
        chk("drop_next", 32'(gnt_o), 32'h8);

        // Pointer wraps from 3 to 0.
        done_i = 1'b1;
        push(4'b0001, 0);
        cyc();
        done_i = 1'b0;
        chk("wrap_bub", 32'(gnt_o), 0);
        cyc();
        chk("wrap_gnt", 32'(gnt_o), 1);
        done_i = 1'b1;
        req_i  = '0;
        cyc();
        done_i = 1'b0;

        // Reset mid-grant drops outputs and restarts search at 0.
        req_i = 4'b0110;
        push(4'b0010, 1);
        cyc();
        done_i = 1'b1;
        cyc();
        done_i = 1'b0;
        push(4'b0100, 2);
        cyc();
        chk("mr_pre", 32'(gnt_o), 32'h4);
        reset = 1'b1;
        cyc();
        chk("mr_gnt", 32'(gnt_o), 0);
        chk("mr_idx", 32'(gnt_idx_o), 0);
        chk("mr_vld", 32'(gnt_valid_o), 0);
        reset = 1'b0;
        push(4'b0010, 1);
        cyc();
        chk("mr_after", 32'(gnt_o), 32'h2);
        done_i = 1'b1;
        req_i  = '0;
        cyc();
        done_i = 1'b0;
        cyc();
        cyc();

        chk("sb_drain", 32'(exp_q.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
